// File: rtl/uart_sha256_host.sv
// Host-side initiator for the UART SHA-256 framing protocol: frames 0x01/payload/0xFF onto
// the line and collects the 32-byte big-endian digest, with minimal UART TX/RX cores.
module uart_tx_core #(
  parameter int BAUD_DIV = 174
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_busy_o,
  output logic       tx_o
);
  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

  logic [9:0]    shreg_q;
  logic [3:0]    bit_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '1;
      bit_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (!busy_q) begin
      if (tx_start_i) begin
        shreg_q <= {1'b1, tx_data_i, 1'b0};
        bit_q   <= '0;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end
    end else if (cnt_q == CW'(BAUD_DIV - 1)) begin
      cnt_q <= '0;
      if (bit_q == 4'd9) begin
        busy_q  <= 1'b0;
        shreg_q <= '1;
      end else begin
        shreg_q <= {1'b1, shreg_q[9:1]};
        bit_q   <= bit_q + 4'd1;
      end
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tx_busy_o = busy_q;
  assign tx_o      = shreg_q[0];
endmodule

module uart_rx_core #(
  parameter int BAUD_DIV = 174
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o
);
  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

  logic          rx_s1_q, rx_s2_q, active_q, valid_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    bit_q;
  logic [7:0]    shreg_q, data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      active_q <= 1'b0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      data_q   <= '0;
    end else begin
      rx_s1_q <= rx_i;
      rx_s2_q <= rx_s1_q;
      valid_q <= 1'b0;
      if (!active_q) begin
        // Half-bit preload so every later sample lands near mid-bit.
        if (!rx_s2_q) begin
          active_q <= 1'b1;
          cnt_q    <= CW'(BAUD_DIV / 2);
          bit_q    <= '0;
        end
      end else if (cnt_q == CW'(BAUD_DIV - 1)) begin
        cnt_q <= '0;
        bit_q <= bit_q + 4'd1;
        if (bit_q == 4'd0) begin
          if (rx_s2_q) active_q <= 1'b0;
        end else if (bit_q == 4'd9) begin
          active_q <= 1'b0;
          if (rx_s2_q) begin
            valid_q <= 1'b1;
            data_q  <= shreg_q;
          end
        end else begin
          shreg_q <= {rx_s2_q, shreg_q[7:1]};
        end
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign rx_data_o  = data_q;
  assign rx_valid_o = valid_q;
endmodule

module uart_sha256_host #(
  parameter int CLK_FREQ       = 20_000_000,
  parameter int BAUD           = 115200,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic         clk,
  input  logic         rst,
  output logic         uart_tx,
  input  logic         uart_rx,
  input  logic [7:0]   msg_data,
  input  logic         msg_valid,
  input  logic         msg_last,
  output logic         msg_ready,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         truncated,
  output logic         resp_timeout,
  output logic         busy
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE, SEND_START, SEND_PAYLOAD, SEND_TERM, WAIT_TX_IDLE, WAIT_RESP, DONE
  } state_t;

  state_t        state_q;
  logic          tx_start_q;
  logic [7:0]    tx_data_q;
  logic          drain_q, trunc_q, dv_q, to_q;
  logic [4:0]    idx_q;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [255:0]  digest_q;

  logic          tx_busy, rx_valid, can_tx;
  logic [7:0]    rx_data;

  uart_tx_core #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk(clk), .rst(rst), .tx_start_i(tx_start_q), .tx_data_i(tx_data_q),
    .tx_busy_o(tx_busy), .tx_o(uart_tx)
  );

  uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk(clk), .rst(rst), .rx_i(uart_rx), .rx_data_o(rx_data), .rx_valid_o(rx_valid)
  );

  // A start pulse in flight blocks the next one until tx_busy has had a cycle to rise.
  assign can_tx    = !tx_busy && !tx_start_q;
  assign msg_ready = drain_q || (state_q == SEND_PAYLOAD && can_tx);
  assign tmo_d     = tmo_q + TW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      drain_q    <= 1'b0;
      trunc_q    <= 1'b0;
      dv_q       <= 1'b0;
      to_q       <= 1'b0;
      idx_q      <= '0;
      tmo_q      <= '0;
      digest_q   <= '0;
    end else begin
      tx_start_q <= 1'b0;
      dv_q       <= 1'b0;
      to_q       <= 1'b0;
      if (drain_q && msg_valid && msg_last) drain_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (msg_valid && !drain_q) state_q <= SEND_START;
        end
        SEND_START: begin
          if (can_tx) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= 8'h01;
            trunc_q    <= 1'b0;
            state_q    <= SEND_PAYLOAD;
          end
        end
        SEND_PAYLOAD: begin
          if (msg_valid && can_tx) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= msg_data;
            if (msg_data == 8'hFF) begin
              state_q <= WAIT_TX_IDLE;
              // The far end has already seen its terminator; swallow the rest of the message.
              if (!msg_last) begin
                trunc_q <= 1'b1;
                drain_q <= 1'b1;
              end
            end else if (msg_last) begin
              state_q <= SEND_TERM;
            end
          end
        end
        SEND_TERM: begin
          if (can_tx) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= 8'hFF;
            state_q    <= WAIT_TX_IDLE;
          end
        end
        WAIT_TX_IDLE: begin
          idx_q <= '0;
          tmo_q <= '0;
          if (can_tx) state_q <= WAIT_RESP;
        end
        WAIT_RESP: begin
          if (to_q) begin
            state_q <= IDLE;
          end else if (rx_valid) begin
            digest_q <= {digest_q[247:0], rx_data};
            idx_q    <= idx_q + 5'd1;
            tmo_q    <= '0;
            if (idx_q == 5'd31) begin
              dv_q    <= 1'b1;
              state_q <= DONE;
            end
          end else begin
            tmo_q <= tmo_d;
            if (tmo_d == TW'(TIMEOUT_CYCLES - 1)) to_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign digest       = digest_q;
  assign digest_valid = dv_q;
  assign truncated    = trunc_q;
  assign resp_timeout = to_q;
  assign busy         = (state_q != IDLE);
endmodule
